dmem_load_store_unit: RTL and testbench

//  Load/store unit between the core's memory request port and the shared memory block's dmem port.

---
 rtl/dmem_load_store_unit_if.sv | 30 +++
 rtl/dmem_load_store_unit.sv | 118 +++++++++++
 tb/tb_dmem_load_store_unit.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_load_store_unit_if.sv
// Request/response and dmem bus of the load/store unit.
// slave = the LSU; master = the core plus memory environment around it.
interface dmem_load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        dmem_wren;
  logic [31:0] dmem_address;
  logic [31:0] dmem_data_in;
  logic [2:0]  dmem_funct3;
  logic [31:0] dmem_data_out;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, dmem_data_out,
    output req_ready, rsp_valid, rsp_rdata, rsp_error,
    output dmem_wren, dmem_address, dmem_data_in, dmem_funct3
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, dmem_data_out,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error,
    input  dmem_wren, dmem_address, dmem_data_in, dmem_funct3
  );
endinterface

// File: rtl/dmem_load_store_unit.sv
// Single-outstanding load/store unit between the core request port and the dmem port.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned H/W accesses are rejected with rsp_error.
module dmem_load_store_unit #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  dmem_load_store_unit_if.slave         bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

  localparam logic [1:0] WAIT_LAST = 2'(READ_LATENCY - 1);

  state_t      state_q, state_d;
  logic [1:0]  wait_cnt_q;
  logic [1:0]  addr_lo_q;
  logic [2:0]  funct3_q;
  logic        write_q;
  logic        fire;
  logic        illegal;
  logic        misaligned;
  logic        reject;
  logic        last_wait;

  function automatic logic [31:0] extend(input logic [31:0] word, input logic [2:0] f3,
                                         input logic [1:0] lo);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lo, 3'b000} +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  extend = {{24{b[7]}}, b};
      3'b100:  extend = {24'd0, b};
      3'b001:  extend = {{16{h[15]}}, h};
      3'b101:  extend = {16'd0, h};
      default: extend = word;
    endcase
  endfunction

  assign bus.req_ready = (state_q == S_IDLE) && !reset;
  assign bus.rsp_valid = (state_q == S_RESP);
  assign fire          = bus.req_valid && bus.req_ready;
  assign last_wait     = (state_q == S_WAIT) && (wait_cnt_q == WAIT_LAST);

  // NOTE: every signal written in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    illegal    = 1'b1;
    misaligned = 1'b0;
    case (bus.req_funct3)
      3'b000, 3'b001, 3'b010: illegal = 1'b0;
      3'b100, 3'b101:         illegal = bus.req_write;
      default:                illegal = 1'b1;
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                 ((bus.req_funct3 == 3'b010) && (bus.req_addr[1:0] != 2'b00));
`endif
    reject = illegal || misaligned;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (fire) state_d = reject ? S_RESP : S_ACCESS;
      S_ACCESS: state_d = write_q ? S_RESP : S_WAIT;
      S_WAIT:   if (wait_cnt_q == WAIT_LAST) state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.dmem_wren    <= 1'b0;
      bus.dmem_address <= '0;
      bus.dmem_data_in <= '0;
      bus.dmem_funct3  <= 3'b010;
      bus.rsp_rdata    <= '0;
      bus.rsp_error    <= 1'b0;
      wait_cnt_q       <= '0;
      addr_lo_q        <= '0;
      funct3_q         <= 3'b010;
      write_q          <= 1'b0;
    end else begin
      bus.dmem_wren <= 1'b0;
      if (fire) begin
        addr_lo_q     <= bus.req_addr[1:0];
        funct3_q      <= bus.req_funct3;
        write_q       <= bus.req_write;
        bus.rsp_rdata <= '0;
        bus.rsp_error <= reject;
        if (!reject) begin
          bus.dmem_wren <= bus.req_write;
          if (bus.req_write) begin
            bus.dmem_address <= bus.req_addr;
            bus.dmem_data_in <= bus.req_wdata;
            bus.dmem_funct3  <= bus.req_funct3;
          end else begin
            bus.dmem_address <= {bus.req_addr[31:2], 2'b00};
            bus.dmem_funct3  <= 3'b010;
          end
        end
      end
      if (state_q == S_ACCESS)    wait_cnt_q <= '0;
      else if (state_q == S_WAIT) wait_cnt_q <= wait_cnt_q + 2'd1;
      // Address is held through WAIT, so read data is stable when sampled on the last WAIT edge.
      if (last_wait) bus.rsp_rdata <= extend(bus.dmem_data_out, funct3_q, addr_lo_q);
    end
  end

endmodule

// File: tb/tb_dmem_load_store_unit.sv
// Scoreboard bench for dmem_load_store_unit: randomized requests against a byte-level memory model,
// with a latency-pipelined dmem stand-in and a monitor that checks responses and dmem traffic.
module tb_dmem_load_store_unit;
  localparam int LAT = 3;

  typedef struct {
    int          cyc;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f3;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  exp_t rsp_q[$];
  exp_t wr_q[$];
  exp_t rd_q[$];

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  logic [31:0] stage   [LAT];

  dmem_load_store_unit_if bus();

  dmem_load_store_unit #(.READ_LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // dmem stand-in: read data appears LAT cycles after the address is presented.
  assign bus.dmem_data_out = stage[LAT-1];
  always @(posedge clk) begin
    stage[0] <= mem[bus.dmem_address[9:2]];
    for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
    if (bus.dmem_wren) begin
      case (bus.dmem_funct3)
        3'b000:  mem[bus.dmem_address[9:2]][{bus.dmem_address[1:0], 3'b000} +: 8] <= bus.dmem_data_in[7:0];
        3'b001:  mem[bus.dmem_address[9:2]][{bus.dmem_address[1], 4'b0000} +: 16] <= bus.dmem_data_in[15:0];
        default: mem[bus.dmem_address[9:2]] <= bus.dmem_data_in;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: RV32I load/store semantics on a word array with plain arithmetic.
  task automatic model(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input int t);
    bit          legal;
    bit          mis;
    int          idx;
    int          sh;
    logic [31:0] word;
    logic [31:0] val;
    exp_t        e;
    legal = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    mis   = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    mis = ((f3 == 3'd1 || f3 == 3'd5) && (addr % 2 != 0)) || (f3 == 3'd2 && (addr % 4 != 0));
`endif
    idx  = int'(addr[9:2]);
    word = ref_mem[idx];
    if (!legal || mis) begin
      e = '{t + 1, 32'd0, 32'd1, 3'd0};
      rsp_q.push_back(e);
    end else if (wr) begin
      e = '{t + 1, addr, wdata, f3};
      wr_q.push_back(e);
      e = '{t + 2, 32'd0, 32'd0, 3'd0};
      rsp_q.push_back(e);
      if (f3 == 3'd0) begin
        sh = 8 * (addr % 4);
        word = (word & ~(32'hFF << sh)) | ((wdata & 32'hFF) << sh);
      end else if (f3 == 3'd1) begin
        sh = 16 * ((addr / 2) % 2);
        word = (word & ~(32'hFFFF << sh)) | ((wdata & 32'hFFFF) << sh);
      end else begin
        word = wdata;
      end
      ref_mem[idx] = word;
    end else begin
      case (f3)
        3'd0, 3'd4: begin
          val = (word >> (8 * (addr % 4))) & 32'hFF;
          if (f3 == 3'd0 && val >= 128) val = val - 256;
        end
        3'd1, 3'd5: begin
          val = (word >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
          if (f3 == 3'd1 && val >= 32768) val = val - 65536;
        end
        default: val = word;
      endcase
      e = '{t + 1, addr - (addr % 4), 32'd0, 3'd2};
      rd_q.push_back(e);
      e = '{t + 2 + LAT, val, 32'd0, 3'd0};
      rsp_q.push_back(e);
    end
  endtask

  task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit track, output int t);
    int budget;
    budget = 0;
    t = -1;
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    while (t < 0 && budget <= 50) begin
      @(negedge clk);
      if (bus.req_ready) t = cyc;
      else budget++;
    end
    if (t < 0) check("req_ready_timeout", bus.req_ready, 1'b1);
    else if (track) model(wr, f3, addr, wdata, t);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (bus.rsp_valid) begin
        if (rsp_q.size() == 0) check("rsp_unexpected", bus.rsp_valid, 1'b0);
        else begin
          e = rsp_q.pop_front();
          check("rsp_cycle", cyc, e.cyc);
          check("rsp_rdata", bus.rsp_rdata, e.a);
          check("rsp_error", bus.rsp_error, e.b);
        end
      end else if (rsp_q.size() > 0 && rsp_q[0].cyc <= cyc) begin
        e = rsp_q.pop_front();
        check("rsp_valid_missing", bus.rsp_valid, 1'b1);
      end
      if (bus.dmem_wren) begin
        if (wr_q.size() == 0) check("wren_unexpected", bus.dmem_wren, 1'b0);
        else begin
          e = wr_q.pop_front();
          check("wren_cycle", cyc, e.cyc);
          check("st_address", bus.dmem_address, e.a);
          check("st_data_in", bus.dmem_data_in, e.b);
          check("st_funct3", 32'(bus.dmem_funct3), 32'(e.f3));
        end
      end else if (wr_q.size() > 0 && wr_q[0].cyc <= cyc) begin
        e = wr_q.pop_front();
        check("wren_missing", bus.dmem_wren, 1'b1);
      end
      if (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
        e = rd_q.pop_front();
        check("ld_address", bus.dmem_address, e.a);
        check("ld_funct3", 32'(bus.dmem_funct3), 32'(e.f3));
      end
    end
  end

  initial begin
    int t;
    int hs[3];
    logic [31:0] r;
    for (int i = 0; i < 256; i++) begin
      r = $urandom();
      mem[i] = r;
      ref_mem[i] = r;
    end
    for (int i = 0; i < LAT; i++) stage[i] = '0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = 3'd0;
    bus.req_addr = '0; bus.req_wdata = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", bus.req_ready, 1'b0);
    check("reset_rsp_valid", bus.rsp_valid, 1'b0);
    check("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("reset_rsp_error", bus.rsp_error, 1'b0);
    check("reset_wren", bus.dmem_wren, 1'b0);
    check("reset_address", bus.dmem_address, 32'd0);
    check("reset_data_in", bus.dmem_data_in, 32'd0);
    check("reset_funct3", 32'(bus.dmem_funct3), 32'd2);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("idle_req_ready", bus.req_ready, 1'b1);
    @(posedge clk); #1;

    // LED register store, then the sign/zero-extension vectors on word 0x80F07F01.
    issue(1'b1, 3'd2, 32'hFFFF_FFFC, 32'hFFFF_0000, 1'b1, t); idle(2);
    issue(1'b1, 3'd2, 32'h0000_0040, 32'h80F0_7F01, 1'b1, t); idle(1);
    issue(1'b0, 3'd0, 32'h0000_0043, 32'd0, 1'b1, t); idle(1);
    issue(1'b0, 3'd4, 32'h0000_0043, 32'd0, 1'b1, t); idle(1);
    issue(1'b0, 3'd1, 32'h0000_0042, 32'd0, 1'b1, t); idle(1);
    issue(1'b0, 3'd5, 32'h0000_0042, 32'd0, 1'b1, t); idle(1);
    issue(1'b0, 3'd2, 32'h0000_0040, 32'd0, 1'b1, t); idle(1);
    // Misaligned word load, illegal funct3 codes.
    issue(1'b0, 3'd2, 32'h0000_1002, 32'd0, 1'b1, t); idle(1);
    issue(1'b0, 3'd3, 32'h0000_0010, 32'd0, 1'b1, t); idle(1);
    issue(1'b1, 3'd4, 32'h0000_0010, 32'h1234_5678, 1'b1, t); idle(1);

    // Back-to-back stores with req_valid held high.
    for (int i = 0; i < 3; i++) issue(1'b1, 3'd2, 32'h100 + 32'(4 * i), $urandom(), 1'b1, hs[i]);
    idle(1);
    check("b2b_gap_1", 32'(hs[1] - hs[0]), 32'd3);
    check("b2b_gap_2", 32'(hs[2] - hs[1]), 32'd3);

    // Reset during ACCESS of a load aborts it.
    issue(1'b0, 3'd2, 32'h0000_0080, 32'd0, 1'b0, t);
    bus.req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("abort_req_ready", bus.req_ready, 1'b1);
    check("abort_wren", bus.dmem_wren, 1'b0);
    for (int i = 0; i < LAT + 3; i++) begin
      @(negedge clk);
      check("abort_no_rsp", bus.rsp_valid, 1'b0);
    end
    @(posedge clk); #1;

    for (int n = 0; n < 80; n++) begin
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom(), $urandom(), 1'b1, t);
      idle($urandom_range(0, 2));
    end

    for (int i = 0; i < 60 && (rsp_q.size() + wr_q.size() + rd_q.size()) != 0; i++) @(negedge clk);
    check("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
    check("wr_queue_drained", 32'(wr_q.size()), 32'd0);
    check("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
